// File: rtl/sdr_16_port_arb.sv
// Port arbiter and refresh scheduler sharing one SDR SDRAM control FSM among up to four ports.
// Define SDR_16_RR_ARB_EN for round-robin arbitration; otherwise fixed priority (port 0 highest).
module sdr_16_port_arb #(
  parameter int NR_OF_PORTS  = 4,
  parameter int RFR_INTERVAL = 780
) (
  input  logic                   sdram_clk,
  input  logic                   sdram_rst,
  input  logic [NR_OF_PORTS-1:0] port_empty,
  output logic [NR_OF_PORTS-1:0] port_rd_adr,
  output logic [NR_OF_PORTS-1:0] port_rd_data,
  output logic [NR_OF_PORTS-1:0] grant,
  output logic [1:0]             grant_id,
  output logic                   fifo_empty,
  input  logic                   fifo_rd_adr,
  input  logic                   fifo_rd_data,
  input  logic                   state_idle,
  input  logic                   cmd_aref,
  output logic                   refresh_req
);

  typedef enum logic [1:0] {ARB_IDLE, ARB_GNT, ARB_BUSY} arb_t;

  arb_t                   state;
  logic [15:0]            tmr;
  logic [2:0]             pend;
  logic                   tick;
  logic [NR_OF_PORTS-1:0] req;
  logic [1:0]             win;
  logic [NR_OF_PORTS-1:0] win_oh;

  assign req  = ~port_empty;
  assign tick = (tmr == 16'd0);

  always_comb begin : sel
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    win   = grant_id;
`ifdef SDR_16_RR_ARB_EN
    // Search begins one past the previous owner so every requester gets a turn.
    for (int k = 1; k <= NR_OF_PORTS; k++) begin
      idx = (int'(grant_id) + k) % NR_OF_PORTS;
      if (!found && req[idx]) begin
        win   = 2'(idx);
        found = 1'b1;
      end
    end
`else
    for (int i = NR_OF_PORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        win   = 2'(i);
        found = 1'b1;
      end
    end
`endif
    for (int i = 0; i < NR_OF_PORTS; i++) win_oh[i] = (win == 2'(i));
  end

  // Grant is one-hot, so scanning it is equivalent to indexing by grant_id.
  always_comb begin
    fifo_empty = 1'b1;
    for (int i = 0; i < NR_OF_PORTS; i++)
      if (grant[i]) fifo_empty = port_empty[i];
  end

  assign port_rd_adr  = {NR_OF_PORTS{fifo_rd_adr}} & grant;
  assign port_rd_data = {NR_OF_PORTS{fifo_rd_data}} & grant;
  assign refresh_req  = (pend != 3'd0) && (state == ARB_IDLE);

  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) tmr <= 16'(RFR_INTERVAL - 1);
    else if (tick) tmr <= 16'(RFR_INTERVAL - 1);
    else           tmr <= tmr - 16'd1;
  end

  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) pend <= 3'd0;
    else begin
      case ({tick, cmd_aref})
        2'b10:   if (pend != 3'd7) pend <= pend + 3'd1;
        2'b01:   if (pend != 3'd0) pend <= pend - 3'd1;
        default: pend <= pend;
      endcase
    end
  end

  // A pending refresh only blocks new grants; an owner keeps the FSM until it idles.
  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      state    <= ARB_IDLE;
      grant    <= '0;
      grant_id <= 2'd0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (state_idle && pend == 3'd0 && |req) begin
            grant    <= win_oh;
            grant_id <= win;
            state    <= ARB_GNT;
          end else begin
            grant <= '0;
          end
        end
        ARB_GNT: if (!state_idle) state <= ARB_BUSY;
        ARB_BUSY: begin
          if (state_idle) begin
            grant <= '0;
            state <= ARB_IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdr_16_port_arb.sv
// Directed bench for sdr_16_port_arb: vector table for arbitration/muxing plus hand sequences
// for refresh timing, pend saturation and asynchronous reset.
module tb_sdr_16_port_arb;

  localparam int NP  = 4;
  localparam int RFR = 16;

`ifdef SDR_16_RR_ARB_EN
  localparam logic [3:0] G1 = 4'b1000, G2 = 4'b0001, G3 = 4'b1000, G4 = 4'b0001;
  localparam logic [1:0] I1 = 2'd3,    I2 = 2'd0,    I3 = 2'd3,    I4 = 2'd0;
`else
  localparam logic [3:0] G1 = 4'b0001, G2 = 4'b0001, G3 = 4'b0001, G4 = 4'b0001;
  localparam logic [1:0] I1 = 2'd0,    I2 = 2'd0,    I3 = 2'd0,    I4 = 2'd0;
`endif

  logic          sdram_clk = 1'b0;
  logic          sdram_rst;
  logic [NP-1:0] port_empty, port_rd_adr, port_rd_data, grant;
  logic [1:0]    grant_id;
  logic          fifo_empty, fifo_rd_adr, fifo_rd_data, state_idle, cmd_aref, refresh_req;

  sdr_16_port_arb #(.NR_OF_PORTS(NP), .RFR_INTERVAL(RFR)) dut (
    .sdram_clk(sdram_clk), .sdram_rst(sdram_rst), .port_empty(port_empty),
    .port_rd_adr(port_rd_adr), .port_rd_data(port_rd_data), .grant(grant),
    .grant_id(grant_id), .fifo_empty(fifo_empty), .fifo_rd_adr(fifo_rd_adr),
    .fifo_rd_data(fifo_rd_data), .state_idle(state_idle), .cmd_aref(cmd_aref),
    .refresh_req(refresh_req)
  );

  always #5 sdram_clk = ~sdram_clk;

  typedef struct {
    logic [3:0] pe;  logic si; logic ra; logic rd; logic aref;
    logic [3:0] g;   logic [1:0] gid; logic fe; logic [3:0] pra; logic [3:0] prd; logic rr;
  } vec_t;

  vec_t tv[20];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(negedge sdram_clk);
      cyc++;
    end
  endtask

  // Reset released on a negedge; window 0 is the cycle before the first active edge.
  task automatic do_reset();
    sdram_rst = 1'b1; port_empty = 4'b1111; state_idle = 1'b1;
    fifo_rd_adr = 1'b0; fifo_rd_data = 1'b0; cmd_aref = 1'b0;
    @(negedge sdram_clk);
    @(negedge sdram_clk);
    sdram_rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    sdram_rst = 1'b1; port_empty = 4'b1111; state_idle = 1'b1;
    fifo_rd_adr = 1'b0; fifo_rd_data = 1'b0; cmd_aref = 1'b0;
    #3;
    chk("rst grant", 32'(grant), 32'h0);
    chk("rst grant_id", 32'(grant_id), 32'h0);
    chk("rst fifo_empty", 32'(fifo_empty), 32'h1);
    chk("rst rd_adr", 32'(port_rd_adr), 32'h0);
    chk("rst rd_data", 32'(port_rd_data), 32'h0);
    chk("rst refresh_req", 32'(refresh_req), 32'h0);
    chk("rst pend", 32'(dut.pend), 32'h0);
    chk("rst tmr", 32'(dut.tmr), 32'(RFR - 1));

    //          pe       si    ra    rd    aref | g        gid   fe    pra      prd      rr
    tv[0]  = '{4'b1111,1'b1,1'b0,1'b0,1'b0, 4'b0000,2'd0,1'b1,4'b0000,4'b0000,1'b0};
    tv[1]  = '{4'b1011,1'b1,1'b0,1'b0,1'b0, 4'b0000,2'd0,1'b1,4'b0000,4'b0000,1'b0};
    tv[2]  = '{4'b1011,1'b1,1'b0,1'b0,1'b0, 4'b0100,2'd2,1'b0,4'b0000,4'b0000,1'b0};
    tv[3]  = '{4'b1011,1'b0,1'b1,1'b0,1'b0, 4'b0100,2'd2,1'b0,4'b0100,4'b0000,1'b0};
    tv[4]  = '{4'b1111,1'b0,1'b0,1'b1,1'b0, 4'b0100,2'd2,1'b1,4'b0000,4'b0100,1'b0};
    tv[5]  = '{4'b1111,1'b1,1'b0,1'b0,1'b0, 4'b0100,2'd2,1'b1,4'b0000,4'b0000,1'b0};
    tv[6]  = '{4'b1111,1'b1,1'b1,1'b1,1'b0, 4'b0000,2'd2,1'b1,4'b0000,4'b0000,1'b0};
    tv[7]  = '{4'b0110,1'b1,1'b0,1'b0,1'b0, 4'b0000,2'd2,1'b1,4'b0000,4'b0000,1'b0};
    tv[8]  = '{4'b0110,1'b0,1'b0,1'b0,1'b0, G1,     I1,  1'b0,4'b0000,4'b0000,1'b0};
    tv[9]  = '{4'b0110,1'b1,1'b0,1'b0,1'b0, G1,     I1,  1'b0,4'b0000,4'b0000,1'b0};
    tv[10] = '{4'b0110,1'b1,1'b0,1'b0,1'b0, 4'b0000,I1,  1'b1,4'b0000,4'b0000,1'b0};
    tv[11] = '{4'b0110,1'b0,1'b0,1'b0,1'b0, G2,     I2,  1'b0,4'b0000,4'b0000,1'b0};
    tv[12] = '{4'b0110,1'b1,1'b0,1'b0,1'b0, G2,     I2,  1'b0,4'b0000,4'b0000,1'b0};
    tv[13] = '{4'b0110,1'b1,1'b0,1'b0,1'b0, 4'b0000,I2,  1'b1,4'b0000,4'b0000,1'b0};
    tv[14] = '{4'b0110,1'b0,1'b0,1'b0,1'b0, G3,     I3,  1'b0,4'b0000,4'b0000,1'b0};
    tv[15] = '{4'b0110,1'b1,1'b0,1'b0,1'b0, G3,     I3,  1'b0,4'b0000,4'b0000,1'b0};
    tv[16] = '{4'b0110,1'b1,1'b0,1'b0,1'b0, 4'b0000,I3,  1'b1,4'b0000,4'b0000,1'b1};
    tv[17] = '{4'b0110,1'b1,1'b0,1'b0,1'b1, 4'b0000,I3,  1'b1,4'b0000,4'b0000,1'b1};
    tv[18] = '{4'b0110,1'b1,1'b0,1'b0,1'b0, 4'b0000,I3,  1'b1,4'b0000,4'b0000,1'b0};
    tv[19] = '{4'b0110,1'b1,1'b0,1'b0,1'b0, G4,     I4,  1'b0,4'b0000,4'b0000,1'b0};

    do_reset();
    for (int i = 0; i < 20; i++) begin
      port_empty = tv[i].pe; state_idle = tv[i].si; fifo_rd_adr = tv[i].ra;
      fifo_rd_data = tv[i].rd; cmd_aref = tv[i].aref;
      #1;
      chk($sformatf("r%0d grant", i), 32'(grant), 32'(tv[i].g));
      chk($sformatf("r%0d grant_id", i), 32'(grant_id), 32'(tv[i].gid));
      chk($sformatf("r%0d fifo_empty", i), 32'(fifo_empty), 32'(tv[i].fe));
      chk($sformatf("r%0d rd_adr", i), 32'(port_rd_adr), 32'(tv[i].pra));
      chk($sformatf("r%0d rd_data", i), 32'(port_rd_data), 32'(tv[i].prd));
      chk($sformatf("r%0d refresh_req", i), 32'(refresh_req), 32'(tv[i].rr));
      wait_to(i + 1);
    end

    // Tick during a port-1 access: refresh waits for release, then blocks regrant until aref.
    do_reset();
    port_empty = 4'b1101; state_idle = 1'b1;
    wait_to(1); state_idle = 1'b0;
    wait_to(18); #1;
    chk("busy tick grant", 32'(grant), 32'h2);
    chk("busy tick refresh_req", 32'(refresh_req), 32'h0);
    wait_to(20); state_idle = 1'b1; #1;
    chk("release edge grant", 32'(grant), 32'h2);
    chk("release edge refresh_req", 32'(refresh_req), 32'h0);
    wait_to(21); #1;
    chk("released grant", 32'(grant), 32'h0);
    chk("released refresh_req", 32'(refresh_req), 32'h1);
    wait_to(23); #1;
    chk("pend blocks grant", 32'(grant), 32'h0);
    wait_to(24); cmd_aref = 1'b1;
    wait_to(25); cmd_aref = 1'b0; #1;
    chk("aref refresh_req", 32'(refresh_req), 32'h0);
    chk("aref grant not yet", 32'(grant), 32'h0);
    wait_to(26); #1;
    chk("regrant port1", 32'(grant), 32'h2);

    // First tick timing, saturation at 7, drain, simultaneous tick+aref.
    do_reset();
    wait_to(15); #1;
    chk("first tick rr low", 32'(refresh_req), 32'h0);
    wait_to(16); #1;
    chk("first tick rr high", 32'(refresh_req), 32'h1);
    wait_to(160); #1;
    chk("pend saturated", 32'(dut.pend), 32'h7);
    chk("sat refresh_req", 32'(refresh_req), 32'h1);
    for (int p = 0; p < 7; p++) begin
      wait_to(160 + p);
      cmd_aref = 1'b1;
      if (p == 6) begin
        #1;
        chk("pend after 6 aref", 32'(dut.pend), 32'h1);
        chk("rr after 6 aref", 32'(refresh_req), 32'h1);
      end
    end
    wait_to(167); cmd_aref = 1'b0; #1;
    chk("pend drained", 32'(dut.pend), 32'h0);
    chk("drained refresh_req", 32'(refresh_req), 32'h0);
    wait_to(176); #1;
    chk("pend after tick", 32'(dut.pend), 32'h1);
    wait_to(191); cmd_aref = 1'b1;
    wait_to(192); cmd_aref = 1'b0; #1;
    chk("pend tick+aref", 32'(dut.pend), 32'h1);

    // Asynchronous reset while the FSM is busy with port 0.
    do_reset();
    port_empty = 4'b1110; state_idle = 1'b1;
    wait_to(1); state_idle = 1'b0;
    wait_to(3); fifo_rd_adr = 1'b1; #1;
    chk("pre-rst grant", 32'(grant), 32'h1);
    #1; sdram_rst = 1'b1; #1;
    chk("async rst grant", 32'(grant), 32'h0);
    chk("async rst fifo_empty", 32'(fifo_empty), 32'h1);
    chk("async rst rd_adr", 32'(port_rd_adr), 32'h0);
    chk("async rst grant_id", 32'(grant_id), 32'h0);
    chk("async rst refresh_req", 32'(refresh_req), 32'h0);
    fifo_rd_adr = 1'b0;
    @(negedge sdram_clk);
    sdram_rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdr_16_port_arb.md
# sdr_16_port_arb

Port arbiter and refresh scheduler in front of the 16-bit SDR SDRAM control FSM.
- Shares the single FSM between up to four requester ports, each with its own egress address/data FIFO.
- Routes the FSM's FIFO-empty input from the granted port and demultiplexes the FSM's FIFO read strobes back to that port.
- Generates the periodic refresh request and accounts for refreshes completed by the FSM.

## Interface
- `NR_OF_PORTS`, default 4: number of requester ports, legal range 1..4.
- `RFR_INTERVAL`, default 780: `sdram_clk` cycles between refresh ticks, legal range 16..65535.
- `sdram_clk` in 1: the single clock.
- `sdram_rst` in 1: reset, asynchronous and active-high.
- `port_empty` in NR_OF_PORTS: per-port egress FIFO empty flag.
- `port_rd_adr` out NR_OF_PORTS: per-port address-FIFO read strobe.
- `port_rd_data` out NR_OF_PORTS: per-port data-FIFO read strobe.
- `grant` out NR_OF_PORTS: one-hot grant, all zero when no port owns the FSM.
- `grant_id` out 2: binary index of the last granted port.
- `fifo_empty` out 1: empty flag presented to the FSM.
- `fifo_rd_adr` in 1: FSM address-FIFO read strobe.
- `fifo_rd_data` in 1: FSM data-FIFO read strobe.
- `state_idle` in 1: FSM is in its idle state.
- `cmd_aref` in 1: one-cycle pulse, one auto-refresh issued by the FSM.
- `refresh_req` out 1: refresh request to the FSM.

## Operation
Arbiter state machine (registered), states ARB_IDLE, ARB_GNT, ARB_BUSY:
- **ARB_IDLE**
  - If `state_idle`=1, `pend`=0 and any `port_empty[i]`=0: select the winner, set `grant`/`grant_id`, go to ARB_GNT.
  - Otherwise stay; `grant`=0.
- **ARB_GNT**
  - If `state_idle`=0, go to ARB_BUSY.
  - Otherwise stay; `grant` is held.
- **ARB_BUSY**
  - If `state_idle`=1: clear `grant`, go to ARB_IDLE.
  - `grant_id` keeps the last winner.

Muxing and request rules:
- `fifo_empty` = `port_empty[grant_id]` when `grant`≠0, else 1. It is combinational from registered grant.
- `port_rd_adr[i]` = `fifo_rd_adr` & `grant[i]`; `port_rd_data[i]` = `fifo_rd_data` & `grant[i]`. Both are combinational.
- `refresh_req` = (`pend`≠0) & (arb state == ARB_IDLE). It is never high while `grant`≠0, so the FSM cannot pick refresh over a granted access.
- A pending refresh blocks new grants. It never pre-empts an access in progress.

Refresh accounting:
- 16-bit down counter `tmr`, reloaded with RFR_INTERVAL-1.
- At `tmr`==0 a tick is generated and `tmr` reloads.
- 3-bit `pend`:
  - +1 on tick, saturating at 7.
  - −1 on `cmd_aref`, saturating at 0.
  - Tick and `cmd_aref` in the same cycle leave `pend` unchanged.
- `cmd_aref` pulses from the FSM's init sequence decrement a zero `pend`; this is a no-op.

Ports beyond NR_OF_PORTS do not exist. Winner selection only considers bits 0..NR_OF_PORTS-1.

## Timing
- Reset values:
  - arb state ARB_IDLE; `grant`=0, `grant_id`=0.
  - `pend`=0, `tmr`=RFR_INTERVAL-1.
  - `refresh_req`=0, `fifo_empty`=1, `port_rd_adr`=0, `port_rd_data`=0.
- Reset mid-access: all of the above take effect immediately (asynchronous). Any in-flight grant is dropped.
- Grant latency: requester `port_empty` falls in cycle N with the FSM idle and `pend`=0 → `grant` high at edge N+1 → `fifo_empty` low in cycle N+1 → FSM leaves idle at edge N+2.
- Grant is released on the first edge after `state_idle` returns high. The next grant can be issued one cycle later (at least one idle cycle between owners).
- First tick occurs RFR_INTERVAL cycles after reset release; subsequent ticks every RFR_INTERVAL cycles.
- `refresh_req` rises the cycle after a tick when the arbiter is idle. Otherwise it rises the cycle after the grant is released.
- A FIFO stays granted until the FSM returns idle, regardless of its `port_empty` flag.

## Configuration
- `SDR_16_RR_ARB_EN` defined: round-robin arbitration.
  - Search starts at `grant_id`+1 modulo NR_OF_PORTS.
  - The first requesting port wins.
- Undefined: fixed priority, port 0 highest, NR_OF_PORTS-1 lowest. `grant_id` is still updated but ignored for selection.

## Test plan
- Reset, `state_idle`=1, all ports empty, RFR_INTERVAL=16 → `refresh_req` rises in cycle 17; `cmd_aref` pulse → `pend` 0, `refresh_req` low.
- Port 2 request with FSM idle → `grant`=4'b0100 one cycle later, `fifo_empty`=0; strobes `fifo_rd_adr`/`fifo_rd_data` → only `port_rd_*[2]` pulse; `state_idle` back high → `grant`=0 next cycle.
- Ports 0 and 3 requesting continuously, `SDR_16_RR_ARB_EN` defined → grants alternate 0,3,0,3. Undefined → always 0.
- Tick arrives while port 1 granted and FSM busy → `refresh_req` stays 0 until release, then 1. No new grant until `cmd_aref`.
- Hold `cmd_aref`=0 for 10×RFR_INTERVAL → `pend` saturates at 7; seven `cmd_aref` pulses → `pend`=0. Simultaneous tick+`cmd_aref` → `pend` unchanged.
- Assert `sdram_rst` while in ARB_BUSY → `grant`=0 and `fifo_empty`=1 without waiting for a clock edge.
